// File: rtl/dtlb_assoc.sv
// N-way set-associative data TLB: registered-address lookups, true-LRU ages per set,
// internal refill victim selection and a flush walk that runs out of reset.
module dtlb_assoc #(
  parameter  int unsigned WAYS       = 4,
  parameter  int unsigned SETS       = 32,
  parameter  int unsigned VPN_WIDTH  = 50,
  parameter  int unsigned DATA_WIDTH = 44,
  localparam int unsigned AGE_BITS   = $clog2(WAYS),
  localparam int unsigned SET_BITS   = $clog2(SETS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_en,
  input  logic [VPN_WIDTH-1:0]  lookup_vpn,
  output logic                  lookup_ready,
  output logic                  hit,
  output logic [AGE_BITS-1:0]   hit_way,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic                  refill_en,
  input  logic [VPN_WIDTH-1:0]  refill_vpn,
  input  logic [DATA_WIDTH-1:0] refill_data0,
  input  logic [DATA_WIDTH-1:0] refill_data1,
  input  logic                  flush_req,
  output logic                  busy,
  output logic                  flush_done
);

  typedef enum logic [1:0] {FLUSH, IDLE, REFILL_WR} state_e;

  state_e                  state_q;
  logic [SET_BITS-1:0]     cnt_q;
  logic [SET_BITS-1:0]     set_q;
  logic                    busy_q;
  logic                    flush_done_q;
  logic                    lk_vld_q;
  logic [VPN_WIDTH-1:0]    lk_vpn_q;
  logic [VPN_WIDTH-1:0]    rf_vpn_q;
  logic [DATA_WIDTH-1:0]   rf_d0_q;
  logic [DATA_WIDTH-1:0]   rf_d1_q;

  logic [WAYS-1:0]                valid_q [SETS];
  logic [WAYS-1:0][AGE_BITS-1:0]  age_q   [SETS];
  logic [VPN_WIDTH-1:0]           vpn_mem [SETS][WAYS];
  logic [DATA_WIDTH-1:0]          d0_mem  [SETS][WAYS];
  logic [DATA_WIDTH-1:0]          d1_mem  [SETS][WAYS];

  logic                           in_refill;
  logic [VPN_WIDTH-1:0]           cmp_vpn;
  logic [WAYS-1:0]                set_valid;
  logic [WAYS-1:0][AGE_BITS-1:0]  set_age;
  logic [WAYS-1:0]                match;
  logic [AGE_BITS-1:0]            match_way;
  logic                           victim_found;
  logic [AGE_BITS-1:0]            victim;
  logic                           upd_en;
  logic [AGE_BITS-1:0]            upd_way;
  logic [AGE_BITS-1:0]            old_age;
  logic [WAYS-1:0][AGE_BITS-1:0]  age_d;

  // Tag compare against the registered set; shared by lookup results and refill duplicate check.
  always_comb begin
    in_refill = (state_q == REFILL_WR);
    cmp_vpn   = in_refill ? rf_vpn_q : lk_vpn_q;
    set_valid = valid_q[set_q];
    set_age   = age_q[set_q];
    match     = '0;
    match_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (set_valid[w] && (vpn_mem[set_q][w] == cmp_vpn)) begin
        match[w]  = 1'b1;
        match_way = AGE_BITS'(w);
      end
    end
  end

  // Victim priority: existing copy of the VPN, then lowest invalid way, then the age-0 way.
  always_comb begin
    victim_found = 1'b0;
    victim       = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!victim_found && !set_valid[w]) begin
        victim       = AGE_BITS'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (set_age[w] == '0) victim = AGE_BITS'(w);
      end
    end
    if (|match) victim = match_way;
  end

  always_comb begin
    upd_en  = hit | in_refill;
    upd_way = in_refill ? victim : match_way;
    old_age = set_age[upd_way];
    age_d   = set_age;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (AGE_BITS'(w) == upd_way) begin
        age_d[w] = AGE_BITS'(WAYS - 1);
      end else if (set_valid[w] && (set_age[w] > old_age)) begin
        age_d[w] = set_age[w] - AGE_BITS'(1);
      end
    end
  end

  assign hit          = lk_vld_q & (|match);
  assign hit_way      = hit ? match_way : '0;
  assign rdata0       = hit ? d0_mem[set_q][match_way] : '0;
  assign rdata1       = hit ? d1_mem[set_q][match_way] : '0;
  assign busy         = busy_q;
  assign flush_done   = flush_done_q;
  assign lookup_ready = !busy_q && !refill_en;

  // Control FSM; refill beats flush, flush beats lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FLUSH;
      cnt_q        <= '0;
      busy_q       <= 1'b1;
      flush_done_q <= 1'b0;
      lk_vld_q     <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      lk_vld_q     <= 1'b0;
      case (state_q)
        FLUSH: begin
          cnt_q <= cnt_q + SET_BITS'(1);
          if (cnt_q == SET_BITS'(SETS - 2)) flush_done_q <= 1'b1;
          if (cnt_q == SET_BITS'(SETS - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (refill_en) begin
            state_q  <= REFILL_WR;
            busy_q   <= 1'b1;
            set_q    <= refill_vpn[SET_BITS-1:0];
            rf_vpn_q <= refill_vpn;
            rf_d0_q  <= refill_data0;
            rf_d1_q  <= refill_data1;
          end else if (flush_req) begin
            state_q <= FLUSH;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (lookup_en) begin
            lk_vld_q <= 1'b1;
            lk_vpn_q <= lookup_vpn;
            set_q    <= lookup_vpn[SET_BITS-1:0];
          end
        end
        REFILL_WR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= FLUSH;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Valid/age flops: cleared one set per cycle by the flush walk, else LRU/refill update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == FLUSH) begin
        valid_q[cnt_q] <= '0;
        age_q[cnt_q]   <= '0;
      end else if (upd_en) begin
        age_q[set_q] <= age_d;
        if (in_refill) valid_q[set_q][victim] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && in_refill) begin
      vpn_mem[set_q][victim] <= rf_vpn_q;
      d0_mem[set_q][victim]  <= rf_d0_q;
      d1_mem[set_q][victim]  <= rf_d1_q;
    end
  end

endmodule

// File: doc/dtlb_assoc.md
# dtlb_assoc

Parametrised N-way set-associative data TLB that replaces the fixed 4-way, 32-set, one-module-per-way arrangement with a single block. It does registered-address lookups, keeps true-LRU age state per set, and selects refill victims internally. It also provides a hardware flush sequencer that runs automatically out of reset. It sits between the load/store AGU and the page walker: AGU issues lookups, the walker issues refills on miss.

## Interface
- WAYS, 4, associativity; power of two, 2..8.
- SETS, 32, sets per way; power of two, 4..256. SET_BITS = log2(SETS).
- VPN_WIDTH, 50, virtual page number width (VA[62:13]).
- DATA_WIDTH, 44, width of each of the two translation words per entry.
- AGE_BITS, log2(WAYS), LRU age width (derived; not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- lookup_en  in  1  lookup request; accepted only when lookup_ready=1.
- lookup_vpn  in  VPN_WIDTH  lookup VPN; set index = lookup_vpn[SET_BITS-1:0].
- lookup_ready  out  1  =!busy && !refill_en.
- hit  out  1  result of the lookup accepted in the previous cycle.
- hit_way  out  AGE_BITS  hitting way; 0 on miss.
- rdata0 / rdata1  out  DATA_WIDTH each  translation words of the hitting entry; all-zero on miss.
- refill_en  in  1  install request; accepted when busy=0; has priority over lookup_en.
- refill_vpn  in  VPN_WIDTH  VPN to install.
- refill_data0 / refill_data1  in  DATA_WIDTH each  translation words to install.
- flush_req  in  1  single-cycle pulse; invalidate all entries; accepted when busy=0.
- busy  out  1  flush or refill write phase in progress.
- flush_done  out  1  one-cycle pulse when a flush walk completes.

## Operation
- Storage is SETS×WAYS entries {valid, vpn, data0, data1, age}. Valid and age bits are flops. vpn/data are RAM with registered read address.
- FSM states: FLUSH, IDLE, REFILL_WR.
- FLUSH: a set counter runs 0..SETS-1. Each cycle it clears valid and age for every way of the current set. At counter=SETS-1 the FSM goes to IDLE and pulses flush_done for that cycle. busy=1 throughout.
- IDLE:
  - refill_en → latch the request, read the indexed set, go to REFILL_WR.
  - Otherwise flush_req → counter=0, go to FLUSH.
  - Otherwise lookup_en → lookup.
  - flush_req together with refill_en: the refill wins and flush_req is dropped. The requester must retry while busy=1.
- Lookup: a way hits when valid && stored vpn == registered vpn. At most one way can hit.
- LRU update on hit, applied in the result cycle: hitting way age becomes WAYS-1. Every other valid way whose age exceeds the old hit age decrements by 1. No age update on a miss.
- REFILL_WR: victim selection in priority order:
  - The way already holding refill_vpn, so duplicates never exist.
  - Else the lowest-index invalid way.
  - Else the way with age 0.
  - The victim is written with valid=1, the new vpn/data and age WAYS-1. Other ways are aged as on a hit. Then the FSM returns to IDLE. busy=1 in this state.
- Reset:
  - While rst=1: FSM=FLUSH, counter=0, hit=0, hit_way=0, rdata=0, flush_done=0, busy=1, lookup_ready=0.
  - After rst deasserts, FLUSH runs its full SETS cycles.
  - rst asserted mid-refill or mid-flush abandons the operation and restarts FLUSH at set 0.

## Timing
- Lookup accepted at cycle T → hit/hit_way/rdata valid during T+1. The LRU update is written at the end of T+1.
- Back-to-back lookups at T and T+1 to the same set: the second observes the ages written by the first.
- Refill accepted at T: REFILL_WR during T+1, entry written at end of T+1, busy=0 at T+2. A lookup at T+2 hits the new entry at T+3.
- Flush accepted at T: busy=1 from T+1 for SETS cycles, flush_done during the last of them, lookup_ready=1 the next cycle.
- Outputs hit/rdata carry no state outside the lookup result cycle: hit=0 whenever no lookup was accepted in the prior cycle.

## Test plan
- Reset then idle: busy=1 for exactly SETS (32) cycles after rst drops, flush_done pulse on cycle 32, then a lookup of VPN 0x5 gives hit=0, rdata=0.
- Refill VPN 0x25 with data0=0xABC and data1=0xDEF, then lookup 0x25: hit=1, hit_way=0, rdata0=0xABC, rdata1=0xDEF, one cycle after acceptance.
- Fill ways 0..3 of set 5 (WAYS=4), then look up way 1, then refill a 5th VPN in set 5: the victim is way 0 (oldest), and way 1 still hits.
- Refill an existing VPN with new data: the same way is overwritten, and a subsequent lookup returns the new data with a single hit.
- refill_en and lookup_en in the same cycle: lookup_ready=0 and the lookup produces no hit pulse. flush_req while busy has no effect.
- rst asserted in REFILL_WR: the entry is not installed, FLUSH restarts, and a lookup after the flush misses.
